mul_operand_issue: RTL and testbench
====================================

# mul_operand_issue

Operand queue and issue sequencer that sits directly upstream of the shift-and-add multiplier. It buffers (a, b) operand pairs from a producer valid/ready channel in a DEPTH-entry circular FIFO. It presents them to the multiplier one at a time as a one-shot `in_valid`, and holds off the next issue until the multiplier's `out_valid` pulse returns. A watchdog flags a multiplier that never finishes.

## Interface
- WIDTH, 8, operand width; matches multiplier `WIDTH`.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TIMEOUT, 2*WIDTH+4, maximum WAIT cycles before the watchdog fires.

- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- s_valid  in  1  producer offers a pair.
- s_ready  out  1  queue accepts; equals (count < DEPTH), forced 0 while rst_n low.
- s_a  in  WIDTH  operand a.
- s_b  in  WIDTH  operand b.
- mul_in_valid  out  1  registered issue strobe to multiplier `in_valid`.
- mul_a  out  WIDTH  registered operand a to multiplier.
- mul_b  out  WIDTH  registered operand b to multiplier.
- mul_in_ready  in  1  multiplier `in_ready` (= !busy).
- mul_out_valid  in  1  multiplier `out_valid` (finish).
- count  out  $clog2(DEPTH+1)  entries currently queued.
- inflight  out  1  high when the FSM is not in IDLE.
- timeout_err  out  1  sticky watchdog error.

## Operation
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH)+1 bits, including a wrap bit.
  - Empty when the pointers are equal; full when the indices match and the wrap bits differ.
  - Enqueue on s_valid && s_ready. Dequeue only on an FSM pop.
  - Enqueue and pop in the same cycle leave count unchanged.
  - s_ready does not depend on a same-cycle pop, so a full queue stalls the producer for one cycle even if a pop occurs.
  - No bypass: an entry spends at least one cycle in the queue.
- FSM states:
  - IDLE: if count>0 && mul_in_ready, pop the head into mul_a/mul_b, set mul_in_valid=1 and go to ISSUE. Otherwise stay.
  - ISSUE: mul_in_valid=1. If mul_in_ready=1 at the edge (multiplier captures), clear mul_in_valid, clear the watchdog and go to WAIT. Otherwise hold ISSUE with operands stable.
  - WAIT: the watchdog increments each cycle.
    - mul_out_valid=1 → IDLE.
    - The watchdog reaching TIMEOUT sets timeout_err and goes to IDLE. A later stray mul_out_valid is ignored.
- mul_out_valid sampled in IDLE or ISSUE is ignored; no state change.
- mul_a/mul_b hold their last issued value outside ISSUE.
- The watchdog counter is $clog2(TIMEOUT+1) bits and saturates. timeout_err is cleared only by reset.
- inflight = (state != IDLE).

## Timing
- Reset (rst_n low, asynchronous):
  - Pointers 0, count 0, state IDLE, watchdog 0.
  - mul_in_valid 0, mul_a 0, mul_b 0, timeout_err 0.
  - inflight 0, s_ready 0.
  - On deassertion s_ready rises without waiting for a clock edge.
- Reset mid-operation drops all queued pairs and any in-flight issue immediately. The multiplier is reset by the same rst_n domain.
- Latency with the queue empty and the multiplier ready:
  - Pair accepted at edge E.
  - count=1 after E.
  - Popped at E+1; mul_in_valid high from E+1 to E+2.
  - Multiplier captures at E+2.
  - The next pop happens no earlier than the edge after mul_out_valid is sampled in WAIT.
- One multiplication in flight at a time. Throughput is 1 per (multiplier latency + 2) cycles.
- The pop edge and an enqueue edge may coincide; both take effect.

## Test plan
- Single pair: s_a=0x0D, s_b=0x05 → mul_in_valid high exactly one cycle, at E+1, with mul_a=0x0D and mul_b=0x05. inflight is high until the cycle after mul_out_valid.
- Fill: with mul_in_ready held 0, push 4 pairs (DEPTH=4) → count=4 and s_ready=0. A fifth push is not accepted. Releasing mul_in_ready issues the pairs in FIFO order.
- Wrap-around: stream 10 distinct pairs 0x01..0x0A against a model multiplier → issue order matches push order, count never exceeds 4, and no pair is lost or duplicated.
- Stall in ISSUE: mul_in_ready drops on the pop edge and is held low 3 cycles → mul_in_valid stays high with stable operands for 4 cycles, then exactly one capture.
- Timeout: mul_out_valid is never returned → after TIMEOUT=20 WAIT cycles, timeout_err=1 and the FSM returns to IDLE and issues the next queued pair. A late mul_out_valid causes no change.
- Reset mid-WAIT with count=2 → all outputs return to reset values immediately. After release, count=0 and no issue occurs without new input.

Source files
------------

// File: rtl/mul_operand_issue.sv
// Operand FIFO + one-at-a-time issue sequencer in front of the shift-and-add multiplier.
// Entry spends >=1 cycle queued; s_ready drops only when full; next issue waits for out_valid or watchdog.
module mul_operand_issue #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 2*WIDTH+4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_a,
  input  logic [WIDTH-1:0]           s_b,
  output logic                       mul_in_valid,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic                       mul_in_ready,
  input  logic                       mul_out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       inflight,
  output logic                       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] WD_MAX  = {TW{1'b1}};
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT-1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]    ptr_diff;
  logic             empty, full, push, pop;

  state_t           state_q, state_d;
  logic             mul_in_valid_q, mul_in_valid_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [TW-1:0]    wdog_q, wdog_d;
  logic             timeout_err_q, timeout_err_d;

  // Wrap bit distinguishes full from empty when the indices coincide.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign ptr_diff = wr_ptr_q - rd_ptr_q;
  assign count    = CW'(ptr_diff);
  assign s_ready  = rst_n && !full;
  assign push     = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q[AW-1:0]] <= s_a;
      mem_b_q[wr_ptr_q[AW-1:0]] <= s_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    mul_in_valid_d = mul_in_valid_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    wdog_d         = wdog_q;
    timeout_err_d  = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (!empty && mul_in_ready) begin
          pop            = 1'b1;
          mul_a_d        = mem_a_q[rd_ptr_q[AW-1:0]];
          mul_b_d        = mem_b_q[rd_ptr_q[AW-1:0]];
          mul_in_valid_d = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mul_in_ready) begin
          mul_in_valid_d = 1'b0;
          wdog_d         = '0;
          state_d        = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wdog_q != WD_MAX) wdog_d = wdog_q + TW'(1);
        // A finish in the same cycle as the watchdog limit wins.
        if (mul_out_valid) begin
          state_d = S_IDLE;
        end else if (wdog_q >= WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mul_in_valid_q <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      wdog_q         <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      mul_in_valid_q <= mul_in_valid_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      wdog_q         <= wdog_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign mul_in_valid = mul_in_valid_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign inflight     = (state_q != S_IDLE);
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mul_operand_issue.sv
// Directed bench for mul_operand_issue: drives and samples on the falling clock edge.
module tb_mul_operand_issue;

  logic       clk, rst_n;
  logic       s_valid, s_ready;
  logic [7:0] s_a, s_b;
  logic       mul_in_valid;
  logic [7:0] mul_a, mul_b;
  logic       mul_in_ready, mul_out_valid;
  logic [2:0] count;
  logic       inflight, timeout_err;

  int n_vec = 0;
  int n_bad = 0;
  int max_cnt;
  logic [15:0] src[$];
  logic [15:0] got[$];
  logic [15:0] exp_q[$];

  mul_operand_issue #(.WIDTH(8), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_in_ready(mul_in_ready), .mul_out_valid(mul_out_valid),
    .count(count), .inflight(inflight), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model multiplier (3-cycle busy) plus producer fed from src; captures issued pairs into got.
  task automatic run(input int want, input int limit);
    int busy;
    int cyc;
    busy = 0;
    cyc = 0;
    max_cnt = 0;
    got.delete();
    while (!(got.size() == want && busy == 0 && !inflight && !mul_out_valid) && cyc < limit) begin
      tick();
      cyc++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      mul_out_valid = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) mul_out_valid = 1'b1;
      end
      mul_in_ready = (busy == 0);
      if (mul_in_valid && mul_in_ready) begin
        got.push_back({mul_a, mul_b});
        busy = 3;
      end
      if (src.size() > 0) begin
        s_valid = 1'b1;
        {s_a, s_b} = src[0];
        if (s_ready) void'(src.pop_front());
      end else begin
        s_valid = 1'b0;
      end
    end
    chk("run_in_time", 32'(cyc < limit), 32'd1);
  endtask

  initial begin
    int nhi;
    rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0;
    mul_in_ready = 1'b0; mul_out_valid = 1'b0;

    // Reset state
    tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_in_valid", mul_in_valid, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_err", timeout_err, 0);
    rst_n = 1'b1;
    #1 chk("rst_release_s_ready", s_ready, 1);

    // Single pair
    tick(); s_valid = 1; s_a = 8'h0D; s_b = 8'h05; mul_in_ready = 1;
    tick(); s_valid = 0;
    chk("single_count1", count, 1);
    chk("single_noissue_yet", mul_in_valid, 0);
    tick();
    chk("single_issue", mul_in_valid, 1);
    chk("single_a", mul_a, 8'h0D);
    chk("single_b", mul_b, 8'h05);
    chk("single_inflight", inflight, 1);
    chk("single_count0", count, 0);
    tick();
    chk("single_one_cycle", mul_in_valid, 0);
    chk("single_wait", inflight, 1);
    mul_in_ready = 0;
    tick();
    chk("single_wait2", inflight, 1);
    mul_out_valid = 1; mul_in_ready = 1;
    tick(); mul_out_valid = 0;
    chk("single_done", inflight, 0);

    // Fill with multiplier not ready
    mul_in_ready = 0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_a = 8'(8'h11 + i); s_b = 8'(8'h21 + i);
      tick();
    end
    s_valid = 1; s_a = 8'h15; s_b = 8'h25;
    chk("fill_count4", count, 4);
    chk("fill_s_ready", s_ready, 0);
    tick();
    chk("fill_fifth_rejected", count, 4);
    s_valid = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(8'h11 + i), 8'(8'h21 + i)});
    run(4, 200);
    chk("fill_issued", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("fill_order%0d", i), got[i], exp_q[i]);
    chk("fill_drained", count, 0);

    // Wrap-around stream
    src.delete(); exp_q.delete();
    for (int i = 1; i <= 10; i++) begin
      src.push_back({8'(i), 8'(8'hA0 + i)});
      exp_q.push_back({8'(i), 8'(8'hA0 + i)});
    end
    run(10, 600);
    chk("wrap_issued", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk($sformatf("wrap_order%0d", i), got[i], exp_q[i]);
    chk("wrap_max_count_ok", 32'(max_cnt <= 4), 1);
    chk("wrap_drained", count, 0);
    s_valid = 0; mul_out_valid = 0;

    // Stall in ISSUE
    tick(); s_valid = 1; s_a = 8'h5A; s_b = 8'hA5; mul_in_ready = 1;
    tick(); s_valid = 0;
    nhi = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (mul_in_valid) begin
        nhi++;
        chk("stall_a", mul_a, 8'h5A);
        chk("stall_b", mul_b, 8'hA5);
      end
      mul_in_ready = (k >= 3);
    end
    chk("stall_valid_cycles", nhi, 4);
    chk("stall_in_wait", inflight, 1);
    mul_out_valid = 1;
    tick(); mul_out_valid = 0;
    chk("stall_done", inflight, 0);
    chk("stall_no_reissue", mul_in_valid, 0);

    // Watchdog timeout
    chk("to_err_clear", timeout_err, 0);
    s_valid = 1; s_a = 8'h31; s_b = 8'h41; mul_in_ready = 1;
    tick(); s_a = 8'h32; s_b = 8'h42;
    tick(); s_valid = 0;
    chk("to_issue1", mul_in_valid, 1);
    chk("to_a1", mul_a, 8'h31);
    tick();
    chk("to_captured", mul_in_valid, 0);
    repeat (19) tick();
    chk("to_err_before", timeout_err, 0);
    chk("to_wait_before", inflight, 1);
    tick();
    chk("to_err_set", timeout_err, 1);
    chk("to_idle", inflight, 0);
    chk("to_queued", count, 1);
    mul_in_ready = 0; mul_out_valid = 1;
    tick(); mul_out_valid = 0;
    chk("to_stray_idle", inflight, 0);
    chk("to_stray_noissue", mul_in_valid, 0);
    chk("to_stray_count", count, 1);
    mul_in_ready = 1;
    tick();
    chk("to_issue2", mul_in_valid, 1);
    chk("to_a2", mul_a, 8'h32);
    chk("to_b2", mul_b, 8'h42);
    tick();
    mul_out_valid = 1;
    tick(); mul_out_valid = 0;
    chk("to_done2", inflight, 0);
    chk("to_err_sticky", timeout_err, 1);

    // Reset mid-WAIT with two queued
    s_valid = 1; s_a = 8'h51; s_b = 8'h61;
    tick(); s_a = 8'h52; s_b = 8'h62;
    tick(); s_a = 8'h53; s_b = 8'h63;
    tick(); s_valid = 0;
    chk("mid_count2", count, 2);
    chk("mid_wait", inflight, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_valid", mul_in_valid, 0);
    chk("mid_rst_a", mul_a, 0);
    chk("mid_rst_b", mul_b, 0);
    chk("mid_rst_err", timeout_err, 0);
    tick(); rst_n = 1;
    #1 chk("mid_release_s_ready", s_ready, 1);
    nhi = 0;
    repeat (6) begin
      tick();
      if (mul_in_valid) nhi++;
    end
    chk("post_rst_no_issue", nhi, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_idle", inflight, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
